// File: rtl/mig7_stream_writer.sv
// mig7_stream_writer: streams DATA_WIDTH words into a circular DDR3 region through
// the MIG app interface, issuing one write command and one write-data beat per word.
module mig7_stream_writer #(
    parameter int unsigned ADDR_WIDTH = 28,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned WORDS      = 1048576,
    parameter int unsigned ADDR_STEP  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_calib_complete,
    input  logic                    restart,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_rdy,
    output logic                    app_sr_req,
    output logic                    app_ref_req,
    output logic                    app_zq_req,
    output logic                    wrap,
    output logic [31:0]             word_cnt
);
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [IW-1:0]         LAST_IDX = IW'(WORDS - 1);

    logic                  cal_q, cal_d;
    logic                  cmd_pend_q, cmd_pend_d;
    logic                  dat_pend_q, dat_pend_d;
    logic                  last_q, last_d;
    logic                  wrap_q, wrap_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  drain_ok, accept, complete, at_last;

    // The stage can take a new word in the same cycle its outstanding handshakes finish.
    assign drain_ok = (!cmd_pend_q || app_rdy) && (!dat_pend_q || app_wdf_rdy);
    assign wr_ready = cal_q && drain_ok;

    assign app_addr     = addr_q;
    assign app_cmd      = 3'b000;
    assign app_en       = cmd_pend_q;
    assign app_wdf_data = data_q;
    assign app_wdf_wren = dat_pend_q;
    assign app_wdf_end  = dat_pend_q;
    assign app_wdf_mask = '0;
    assign app_sr_req   = 1'b0;
    assign app_ref_req  = 1'b0;
    assign app_zq_req   = 1'b0;
    assign wrap         = wrap_q;
    assign word_cnt     = cnt_q;

    always_comb begin
        accept     = wr_valid && wr_ready;
        complete   = (cmd_pend_q || dat_pend_q) && drain_ok;
        at_last    = idx_q == LAST_IDX;
        cal_d      = init_calib_complete;
        cmd_pend_d = accept || (cmd_pend_q && !app_rdy);
        dat_pend_d = accept || (dat_pend_q && !app_wdf_rdy);
        addr_d     = accept ? ptr_q : addr_q;
        data_d     = accept ? wr_data : data_q;
        last_d     = accept ? at_last : last_q;
        ptr_d      = restart ? BASE : !accept ? ptr_q : at_last ? BASE : ptr_q + STEP;
        idx_d      = restart ? '0 : !accept ? idx_q : at_last ? '0 : idx_q + IW'(1);
        cnt_d      = cnt_q + {31'd0, complete};
        wrap_d     = complete && last_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cal_q      <= 1'b0;
            cmd_pend_q <= 1'b0;
            dat_pend_q <= 1'b0;
            last_q     <= 1'b0;
            wrap_q     <= 1'b0;
            addr_q     <= BASE;
            ptr_q      <= BASE;
            data_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
        end else begin
            cal_q      <= cal_d;
            cmd_pend_q <= cmd_pend_d;
            dat_pend_q <= dat_pend_d;
            last_q     <= last_d;
            wrap_q     <= wrap_d;
            addr_q     <= addr_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mig7_stream_writer.sv
// tb_mig7_stream_writer: checks the stream writer against a count/queue based model
// of accepted words, command and data handshakes, completions and region wrapping.
module tb_mig7_stream_writer;
    localparam int AW = 28, DW = 128, BASE = 'h100, WORDS = 4, STEP = 8;

    logic clk = 1'b0, rst = 1'b0, init_calib_complete = 1'b0, restart = 1'b0;
    logic wr_valid = 1'b0, app_rdy = 1'b0, app_wdf_rdy = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic wr_ready, app_en, app_wdf_wren, app_wdf_end, wrap;
    logic app_sr_req, app_ref_req, app_zq_req;
    logic [AW-1:0] app_addr;
    logic [2:0] app_cmd;
    logic [DW-1:0] app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic [31:0] word_cnt;

    always #5 clk = ~clk;

    mig7_stream_writer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .WORDS(WORDS), .ADDR_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete), .restart(restart),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .app_sr_req(app_sr_req), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
        .wrap(wrap), .word_cnt(word_cnt)
    );

    int checks = 0, errors = 0;
    logic cal_m = 1'b0, wrap_m = 1'b0;
    int unsigned acc_n = 0, cmd_n = 0, dat_n = 0, comp_n = 0, k = 0, wrap_seen = 0;
    logic [AW-1:0] addr_qm[$];
    logic [DW-1:0] data_qm[$];
    int idx_qm[$];

    typedef struct packed {
        logic v, ar, wr, en, wren, rdy;
        logic [3:0] cnt;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Called mid-cycle; compares, advances the model, and returns 1 unit after the next edge.
    task automatic eval();
        logic rdy_m, en_m, wren_m, cal_nx;
        rdy_m  = cal_m && (cmd_n == acc_n || app_rdy) && (dat_n == acc_n || app_wdf_rdy);
        en_m   = cmd_n != acc_n;
        wren_m = dat_n != acc_n;
        chk("wr_ready", wr_ready, rdy_m);
        chk("app_en", app_en, en_m);
        chk("app_wdf_wren", app_wdf_wren, wren_m);
        chk("app_wdf_end", app_wdf_end, wren_m);
        chk("word_cnt", word_cnt, comp_n);
        chk("wrap", wrap, wrap_m);
        chk("constants", {app_cmd, app_wdf_mask, app_sr_req, app_ref_req, app_zq_req}, '0);
        if (wrap) wrap_seen++;
        if (en_m && app_rdy) begin
            chk("app_addr", app_addr, addr_qm.pop_front());
            cmd_n++;
        end
        if (wren_m && app_wdf_rdy) begin
            chk("app_wdf_data", app_wdf_data, data_qm.pop_front());
            dat_n++;
        end
        wrap_m = 1'b0;
        if ((cmd_n < dat_n ? cmd_n : dat_n) > comp_n) begin
            comp_n++;
            wrap_m = idx_qm.pop_front() == WORDS - 1;
        end
        if (wr_valid && rdy_m) begin
            addr_qm.push_back(AW'(BASE + k * STEP));
            data_qm.push_back(wr_data);
            idx_qm.push_back(int'(k));
            k = (k + 1) % WORDS;
            acc_n++;
        end
        if (restart) k = 0;
        cal_nx = init_calib_complete;
        @(posedge clk);
        #1;
        cal_m = cal_nx;
    endtask

    task automatic tick();
        #4;
        eval();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_app_en", app_en, 0);
        chk("rst_app_wdf_wren", app_wdf_wren, 0);
        chk("rst_app_wdf_end", app_wdf_end, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_app_addr", app_addr, BASE);
        chk("rst_app_wdf_data", app_wdf_data, 0);
        acc_n = 0; cmd_n = 0; dat_n = 0; comp_n = 0; k = 0;
        cal_m = 1'b0; wrap_m = 1'b0;
        addr_qm.delete(); data_qm.delete(); idx_qm.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int unsigned c0, ws0;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2};

        @(posedge clk);
        #1;
        do_reset();

        // Calibration gate
        wr_valid = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1; wr_data = 'hA5;
        for (int i = 0; i < 50; i++) tick();
        init_calib_complete = 1'b1;
        tick();
        #4;
        chk("cal_ready_plus1", wr_ready, 1);
        eval();
        wr_valid = 1'b0;
        #4;
        chk("first_en", app_en, 1);
        chk("first_addr", app_addr, BASE);
        chk("first_cmd", app_cmd, 0);
        eval();
        repeat (2) tick();

        // Streaming 16 words
        c0 = comp_n;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data = DW'(i);
            tick();
        end
        wr_valid = 1'b0;
        repeat (3) tick();
        chk("stream_cnt", word_cnt, c0 + 16);

        // Split handshakes
        c0 = comp_n;
        for (int i = 0; i < 9; i++) begin
            wr_valid = tbl[i].v; app_rdy = tbl[i].ar; app_wdf_rdy = tbl[i].wr;
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            #4;
            chk("tbl_en", app_en, tbl[i].en);
            chk("tbl_wren", app_wdf_wren, tbl[i].wren);
            chk("tbl_ready", wr_ready, tbl[i].rdy);
            eval();
            chk("tbl_cnt", word_cnt, c0 + tbl[i].cnt);
        end

        // Wrap over a 4-word region
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; wr_valid = 1'b0; restart = 1'b1;
        tick();
        restart = 1'b0;
        c0 = comp_n;
        ws0 = wrap_seen;
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1;
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        wr_valid = 1'b0;
        repeat (3) tick();
        chk("wrap_pulses", wrap_seen - ws0, 2);
        chk("wrap_cnt", word_cnt, c0 + 9);

        // Restart coincident with the accept of the word at BASE+16
        restart = 1'b1;
        tick();
        restart = 1'b0;
        c0 = comp_n;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            restart = i == 2;
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            #4;
            if (i == 3) chk("restart_word_addr", app_addr, BASE + 16);
            eval();
        end
        wr_valid = 1'b0; restart = 1'b0;
        #4;
        chk("restart_next_addr", app_addr, BASE);
        eval();
        repeat (2) tick();
        chk("restart_cnt", word_cnt, c0 + 4);

        // Reset with a command pending
        app_rdy = 1'b0; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        do_reset();
        app_rdy = 1'b1; wr_valid = 1'b1;
        wr_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        #4;
        chk("post_rst_ready", wr_ready, 1);
        eval();
        wr_valid = 1'b0;
        #4;
        chk("post_rst_addr", app_addr, BASE);
        chk("post_rst_cnt", word_cnt, 0);
        eval();
        repeat (2) tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            wr_valid = $urandom_range(0, 99) < 70;
            app_rdy = $urandom_range(0, 99) < 75;
            app_wdf_rdy = $urandom_range(0, 99) < 75;
            restart = $urandom_range(0, 99) < 3;
            if ($urandom_range(0, 99) < 2) init_calib_complete = ~init_calib_complete;
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick();
        end
        wr_valid = 1'b0; restart = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        init_calib_complete = 1'b1;
        repeat (5) tick();
        chk("final_cnt", word_cnt, comp_n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mig7_stream_writer.md
# mig7_stream_writer

Streaming write front-end for the DDR3 controller's user (app) interface, replacing the stub as the master of that interface. Accepts 128-bit words on a valid/ready stream and writes them to consecutive DDR3 locations within a configurable circular region, one MIG write command plus one write-data beat per word. Runs in the controller's UI clock domain and starts only after calibration completes.

## Interface
- ADDR_WIDTH, 28, width of app_addr
- DATA_WIDTH, 128, width of stream and app write data
- BASE_ADDR, 0, app_addr of the region's first word
- WORDS, 1048576, region size in words; must be ≥ 2
- ADDR_STEP, 8, app_addr increment per word (x16 BL8 = 8 columns)
- clk  in  1  UI clock from the controller
- rst  in  1  reset; asynchronous, active-low
- init_calib_complete  in  1  controller calibration done
- restart  in  1  single-cycle pulse; next accepted word goes to BASE_ADDR
- wr_data  in  DATA_WIDTH  stream data
- wr_valid  in  1  stream valid
- wr_ready  out  1  stream ready
- app_addr  out  ADDR_WIDTH  command address
- app_cmd  out  3  command; constant 3'b000 (write)
- app_en  out  1  command valid
- app_rdy  in  1  command accepted when high with app_en
- app_wdf_data  out  DATA_WIDTH  write data
- app_wdf_wren  out  1  write data valid
- app_wdf_end  out  1  equals app_wdf_wren (one beat per burst)
- app_wdf_mask  out  DATA_WIDTH/8  constant 0
- app_wdf_rdy  in  1  data accepted when high with app_wdf_wren
- app_sr_req, app_ref_req, app_zq_req  out  1 each  constant 0
- wrap  out  1  one-cycle pulse when the last word of the region completes
- word_cnt  out  32  completed words since reset, wraps modulo 2^32

## Operation
- One holding stage: registers addr, data, flags cmd_pend, dat_pend. Accept (wr_valid && wr_ready) loads wr_data, current pointer, sets both flags.
- app_en = cmd_pend; app_wdf_wren = app_wdf_end = dat_pend. Command and data channels handshake independently; cmd_pend clears on app_en && app_rdy, dat_pend on app_wdf_wren && app_wdf_rdy. Either may finish first, in either order.
- Word completes on the cycle its last outstanding flag clears; word_cnt increments then.
- wr_ready = cal_q && (!cmd_pend || app_rdy) && (!dat_pend || app_wdf_rdy): back-to-back accept permitted in the cycle the stage drains. Combinational path app_rdy/app_wdf_rdy → wr_ready is intentional.
- cal_q: init_calib_complete registered once. If it falls, wr_ready drops; any pending word still completes.
- Pointer: starts BASE_ADDR; on accept advances by ADDR_STEP; after word index WORDS−1 returns to BASE_ADDR. Word-index counter is log2-sized to WORDS, no arithmetic on app_addr beyond add/reload.
- wrap pulses on completion of a word whose index was WORDS−1.
- restart: pointer and index reload to BASE_ADDR/0. If coincident with an accept, the accepted word uses the pre-restart address; the following word uses BASE_ADDR. No effect on a word already in the holding stage or on word_cnt.

## Timing
- Reset values: wr_ready 0, app_en 0, app_wdf_wren 0, app_wdf_end 0, app_addr BASE_ADDR, app_wdf_data 0, wrap 0, word_cnt 0, constants as listed; pointer BASE_ADDR, cal_q 0.
- Reset asserted mid-operation: pending word discarded immediately, all outputs to reset values asynchronously.
- First wr_ready high: 1 cycle after init_calib_complete is sampled high.
- Accept at cycle N → app_en and app_wdf_wren high at N+1, held with stable addr/data until each handshakes.
- Throughput: 1 word/cycle while app_rdy and app_wdf_rdy stay high.
- word_cnt and wrap update on the clock edge ending the completing handshake.

## Test plan
- Calibration gate: wr_valid high, init_calib_complete low 50 cycles → wr_ready 0, no app_en; raise calib → wr_ready at +1, first command app_addr=0, app_cmd=0.
- Streaming: 16 words 0x0..0xF with both ready high → 16 consecutive app_en/app_wdf_wren cycles, addresses 0,8,…,120, word_cnt=16.
- Split handshake: app_rdy low 3 cycles while app_wdf_rdy high, then reverse → data beat precedes command, each held stable, word_cnt increments once, no new accept until both done.
- Wrap: WORDS=4, BASE_ADDR=0x100, 9 words → addresses 0x100,0x108,0x110,0x118,0x100…, wrap pulses after words 4 and 8, word_cnt=9.
- Restart coincident with accept of word at 0x110 → that word at 0x110, next at BASE_ADDR; word_cnt unaffected.
- Reset mid-stream with command pending and app_rdy low → app_en, app_wdf_wren, wr_ready 0 immediately; after release and calib, first address BASE_ADDR, word_cnt 0.
